// File: rtl/ofmap_drain_scheduler_pkg.sv
// Shared definitions for the ofmap drain scheduler slice.
//   - op_mode_e     : operating mode selected by the controller (MODE1..MODE4)
//   - drain_state_e : scheduler FSM states (IDLE, DRAIN, DONE)
//   - L1/L2/L3      : ofmap side lengths for the mode groups
//   - ofmap_volume  : expected drain volume in bytes for a mode
package ofmap_drain_scheduler_pkg;

    localparam int WIN_BYTES = 16;                    // buffer read window width
    localparam int NUM_W     = $clog2(WIN_BYTES + 1); // 0..16 byte counts
    localparam int CNT_W     = 14;                    // holds up to 12100

    localparam int L1 = 55;
    localparam int L2 = 13;
    localparam int L3 = 13;

    typedef enum logic [1:0] {
        MODE1 = 2'd0,
        MODE2 = 2'd1,
        MODE3 = 2'd2,
        MODE4 = 2'd3
    } op_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } drain_state_e;

    // MODE1/MODE2 share the large layer, MODE3 and MODE4 use their own sides.
    function automatic logic [CNT_W-1:0] ofmap_volume(input op_mode_e m,
                                                      input int l1, input int l2,
                                                      input int l3, input int nf);
        int side;
        case (m)
            MODE3:   side = l2;
            MODE4:   side = l3;
            default: side = l1;
        endcase
        return CNT_W'(nf * side * side);
    endfunction

endpackage

// File: rtl/ofmap_drain_scheduler_if.sv
// Byte-stream bundle between the ofmap buffer, the drain scheduler and the
// compressor.
//   outmap_data / outmap_data_valid_num : buffer read window and its fill
//   send_done                           : buffer marks its final take
//   valid_taken_num                     : bytes consumed from the window
//   cmp_data / cmp_valid_num / cmp_valid: bytes forwarded to the compressor
//   credit_return                       : bytes freed in the downstream FIFO
//
// Handshake: the buffer offers outmap_data_valid_num bytes (its "valid"); the
// scheduler answers in the same cycle with valid_taken_num (its "ready",
// expressed as a byte count). Exactly valid_taken_num bytes transfer on the
// rising edge and the buffer advances its window by that amount; a zero take
// means nothing moved and the window must be held. The compressor side has no
// back-pressure wire: it is protected by credits, returned via credit_return.
interface ofmap_drain_scheduler_if;
    import ofmap_drain_scheduler_pkg::*;

    logic [WIN_BYTES-1:0][7:0] outmap_data;
    logic [NUM_W-1:0]          outmap_data_valid_num;
    logic                      send_done;
    logic [NUM_W-1:0]          valid_taken_num;
    logic [WIN_BYTES-1:0][7:0] cmp_data;
    logic [NUM_W-1:0]          cmp_valid_num;
    logic                      cmp_valid;
    logic [NUM_W-1:0]          credit_return;

    // Environment side: buffer and compressor.
    modport master (
        output outmap_data, outmap_data_valid_num, send_done, credit_return,
        input  valid_taken_num, cmp_data, cmp_valid_num, cmp_valid
    );

    // Scheduler side.
    modport slave (
        input  outmap_data, outmap_data_valid_num, send_done, credit_return,
        output valid_taken_num, cmp_data, cmp_valid_num, cmp_valid
    );

endinterface

// File: rtl/ofmap_drain_scheduler_drain_credit_counter.sv
// Downstream byte-FIFO credit tracker.
//   clk, rst    : clock, synchronous active-high reset (credit -> CREDIT_DEPTH)
//   take_num    : bytes sent downstream this cycle
//   return_num  : bytes freed downstream this cycle
//   credit      : bytes the downstream FIFO can still accept
// Take and return in the same cycle are netted; the result never exceeds
// CREDIT_DEPTH even if the FIFO over-reports freed space.
module drain_credit_counter #(
    parameter int CREDIT_DEPTH = 32,
    parameter int CREDIT_W     = $clog2(CREDIT_DEPTH + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          take_num,
    input  logic [4:0]          return_num,
    output logic [CREDIT_W-1:0] credit
);

    // One spare bit above the widest operand so credit + return cannot wrap.
    localparam int SUM_W = ((CREDIT_W > 5) ? CREDIT_W : 5) + 1;

    logic [SUM_W-1:0] netted;

    // take_num never exceeds credit, so the subtraction cannot underflow.
    assign netted = SUM_W'(credit) + SUM_W'(return_num) - SUM_W'(take_num);

    always_ff @(posedge clk) begin
        if (rst) begin
            credit <= CREDIT_W'(CREDIT_DEPTH);
        end else if (netted > SUM_W'(CREDIT_DEPTH)) begin
            credit <= CREDIT_W'(CREDIT_DEPTH);
        end else begin
            credit <= netted[CREDIT_W-1:0];
        end
    end

endmodule

// File: rtl/ofmap_drain_scheduler.sv
// Drains the output-feature-map buffer into the compressor after a conv.
//   clk, rst            : clock, synchronous active-high reset
//   mode_in/change_mode : mode select, latched only while IDLE
//   drain_start         : begin a drain (honoured only while IDLE)
//   bus (slave)         : buffer window in, compressor bytes/credits out
//   drain_busy          : high while draining
//   drain_done          : one-cycle pulse on a volume-matched completion
//   drain_err           : sticky volume mismatch, cleared at next drain_start
//   byte_count          : bytes sent in the current/last drain
//   stall_cycles        : only with OFMAP_DRAIN_STALL_CNT_EN defined; cycles
//                         where data waited on zero credit (saturating)
//   fsm_state           : debug view of the FSM state
module ofmap_drain_scheduler
    import ofmap_drain_scheduler_pkg::*;
#(
    parameter int MAX_TAKE     = 16,
    parameter int CREDIT_DEPTH = 32,
    parameter int L1_SIZE      = L1,
    parameter int L2_SIZE      = L2,
    parameter int L3_SIZE      = L3,
    parameter int NUM_FILTER   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [1:0]             mode_in,
    input  logic                   change_mode,
    input  logic                   drain_start,
    ofmap_drain_scheduler_if.slave bus,
    output logic                   drain_busy,
    output logic                   drain_done,
    output logic                   drain_err,
    output logic [CNT_W-1:0]       byte_count,
`ifdef OFMAP_DRAIN_STALL_CNT_EN
    output logic [15:0]            stall_cycles,
`endif
    output drain_state_e           fsm_state
);

    localparam int CREDIT_W = $clog2(CREDIT_DEPTH + 1);

    drain_state_e          state_q, state_d;
    op_mode_e              mode_q, start_mode;
    logic [CNT_W-1:0]      exp_vol, remain, sum_count;
    logic [CREDIT_W-1:0]   credit;
    logic [NUM_W-1:0]      avail_cap, credit_cap, remain_cap, take;

    // A mode change arriving with drain_start applies to that drain.
    assign start_mode = change_mode ? op_mode_e'(mode_in) : mode_q;

    // Take = min(window fill, credit, MAX_TAKE, bytes still owed). Each term
    // is clamped to MAX_TAKE first so the final min works on narrow values.
    assign remain     = exp_vol - byte_count;
    assign avail_cap  = (bus.outmap_data_valid_num > NUM_W'(MAX_TAKE)) ?
                        NUM_W'(MAX_TAKE) : bus.outmap_data_valid_num;
    assign credit_cap = (credit > CREDIT_W'(MAX_TAKE)) ?
                        NUM_W'(MAX_TAKE) : credit[NUM_W-1:0];
    assign remain_cap = (remain > CNT_W'(MAX_TAKE)) ?
                        NUM_W'(MAX_TAKE) : remain[NUM_W-1:0];

    always_comb begin
        take = avail_cap;
        if (credit_cap < take) take = credit_cap;
        // Once the full volume is sent the take is pinned at zero until the
        // buffer confirms with send_done.
        if (remain_cap < take) take = remain_cap;
        if (state_q != DRAIN)  take = '0;
    end

    assign sum_count = byte_count + CNT_W'(take);

    assign bus.valid_taken_num = take;
    assign bus.cmp_data        = bus.outmap_data;
    assign bus.cmp_valid_num   = take;
    assign bus.cmp_valid       = (take != '0);

    assign drain_busy = (state_q == DRAIN);
    assign drain_done = (state_q == DONE) && !drain_err;
    assign fsm_state  = state_q;

    drain_credit_counter #(
        .CREDIT_DEPTH (CREDIT_DEPTH),
        .CREDIT_W     (CREDIT_W)
    ) u_credit (
        .clk        (clk),
        .rst        (rst),
        .take_num   (take),
        .return_num (bus.credit_return),
        .credit     (credit)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (drain_start)   state_d = DRAIN;
            DRAIN:   if (bus.send_done) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE1;
            exp_vol    <= ofmap_volume(MODE1, L1_SIZE, L2_SIZE, L3_SIZE, NUM_FILTER);
            byte_count <= '0;
            drain_err  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (change_mode) mode_q <= op_mode_e'(mode_in);
                    if (drain_start) begin
                        exp_vol    <= ofmap_volume(start_mode, L1_SIZE, L2_SIZE,
                                                   L3_SIZE, NUM_FILTER);
                        byte_count <= '0;
                        drain_err  <= 1'b0;
                    end
                end
                DRAIN: begin
                    byte_count <= sum_count;
                    // The final take counts toward the total being judged.
                    if (bus.send_done && (sum_count != exp_vol)) drain_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef OFMAP_DRAIN_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if ((state_q == IDLE) && drain_start) begin
            stall_cycles <= '0;
        end else if ((state_q == DRAIN) && (bus.outmap_data_valid_num != '0) &&
                     (credit == '0) && (stall_cycles != 16'hFFFF)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ofmap_drain_scheduler.sv
// Self-checking bench for ofmap_drain_scheduler: a behavioural model of the
// drain rules, table-driven take sequences, hand-written corner sequences and
// randomized drains.
module tb_ofmap_drain_scheduler;
    import ofmap_drain_scheduler_pkg::*;

    localparam int CD = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   mode_in;
    logic         change_mode;
    logic         drain_start;
    logic         drain_busy;
    logic         drain_done;
    logic         drain_err;
    logic [13:0]  byte_count;
    drain_state_e fsm_state;
`ifdef OFMAP_DRAIN_STALL_CNT_EN
    logic [15:0]  stall_cycles;
`endif

    ofmap_drain_scheduler_if bus ();

    ofmap_drain_scheduler dut (
        .clk          (clk),
        .rst          (rst),
        .mode_in      (mode_in),
        .change_mode  (change_mode),
        .drain_start  (drain_start),
        .bus          (bus.slave),
        .drain_busy   (drain_busy),
        .drain_done   (drain_done),
        .drain_err    (drain_err),
        .byte_count   (byte_count),
`ifdef OFMAP_DRAIN_STALL_CNT_EN
        .stall_cycles (stall_cycles),
`endif
        .fsm_state    (fsm_state)
    );

    always #5 clk = ~clk;

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_err    = 0;

    // ---------------- behavioural model ----------------
    int m_credit, m_count, m_vol, m_mode, m_stall;
    bit m_drain, m_done, m_err;
    int occ;        // bytes sitting in the downstream FIFO
    int row_left;   // bytes left in the current ofmap row (buffer model)
    int m_side;

    // Observations from the latest cycle, for hand-written expectations.
    int obs_take, obs_done, obs_err, obs_busy, obs_count, obs_stall;

    typedef struct {
        int grp;
        int vn;
        int ret;
        bit sd;
        int exp_take;
    } vec_t;
    vec_t tbl[12];

    function automatic int side_of(input int md);
        case (md)
            0, 1:    return 55;
            2:       return 13;
            default: return 13;
        endcase
    endfunction

    function automatic int min2(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic int model_take(input int vn);
        if (!m_drain) return 0;
        return min2(min2(vn, m_credit), min2(16, m_vol - m_count));
    endfunction

    function automatic void model_reset();
        m_credit = CD; m_count = 0; m_mode = 0; m_vol = 4 * 55 * 55;
        m_drain = 0; m_done = 0; m_err = 0; m_stall = 0; occ = 0;
        m_side = 55; row_left = 55;
    endfunction

    function automatic void model_step(input bit r, input int md, input bit chg,
                                       input bit st, input int vn, input int ret,
                                       input bit sd, input int t);
        if (r) begin
            model_reset();
            return;
        end
        if (m_drain && vn > 0 && m_credit == 0 && m_stall < 65535) m_stall++;
        m_credit = min2(m_credit - t + ret, CD);
        occ = occ + t - ret;
        if (occ < 0) occ = 0;
        if (m_done) begin
            m_done = 0;
        end else if (m_drain) begin
            m_count += t;
            if (sd) begin
                m_err = (m_count != m_vol);
                m_drain = 0;
                m_done = 1;
            end
        end else begin
            if (chg) m_mode = md;
            if (st) begin
                m_side = side_of(m_mode);
                m_vol = 4 * m_side * m_side;
                m_count = 0; m_err = 0; m_stall = 0; m_drain = 1;
                row_left = m_side;
            end
        end
    endfunction

    function automatic void check(input string nm, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    function automatic void check_data(input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL cmp_data: got %h expected %h", act, exp);
        end
    endfunction

    // ---------------- driver: one clock cycle ----------------
    // Inputs are applied just after a rising edge, outputs are compared 1ns
    // later, then the model advances across the next rising edge.
    task automatic cycle(input bit r, input int md, input bit chg, input bit st,
                         input int vn, input int ret, input bit sd);
        logic [127:0] d;
        int t;
        d = {$urandom(), $urandom(), $urandom(), $urandom()};
        rst                       = r;
        mode_in                   = md[1:0];
        change_mode               = chg;
        drain_start               = st;
        bus.outmap_data           = d;
        bus.outmap_data_valid_num = vn[4:0];
        bus.credit_return         = ret[4:0];
        bus.send_done             = sd;
        t = model_take(vn);
        #1;
        obs_take  = 32'(bus.valid_taken_num);
        obs_done  = 32'(drain_done);
        obs_err   = 32'(drain_err);
        obs_busy  = 32'(drain_busy);
        obs_count = 32'(byte_count);
        check("take", 32'(bus.valid_taken_num), t);
        check("cmp_valid_num", 32'(bus.cmp_valid_num), t);
        check("cmp_valid", 32'(bus.cmp_valid), 32'(t != 0));
        check_data(bus.cmp_data, d);
        check("drain_busy", 32'(drain_busy), 32'(m_drain));
        check("fsm_drain", 32'(fsm_state == DRAIN), 32'(m_drain));
        check("drain_done", 32'(drain_done), 32'(m_done && !m_err));
        check("drain_err", 32'(drain_err), 32'(m_err));
        check("byte_count", 32'(byte_count), m_count);
`ifdef OFMAP_DRAIN_STALL_CNT_EN
        obs_stall = 32'(stall_cycles);
        check("stall_cycles", 32'(stall_cycles), m_stall);
`else
        obs_stall = 0;
`endif
        @(posedge clk);
        model_step(r, md, chg, st, vn, ret, sd, t);
        #1;
    endtask

    // Drain with a row-shaped buffer (16,16,.. then the row remainder) and
    // credits returned as soon as bytes land downstream.
    task automatic feed(input int stop_at, input bit use_sd, input bit poke_mode,
                        input int budget);
        int n, vn, t, ret;
        n = 0;
        while (m_drain && m_count < stop_at && n < budget) begin
            vn = min2(row_left, 16);
            vn = min2(vn, stop_at - m_count);
            t = model_take(vn);
            ret = min2(occ, 16);
            cycle(0, 2, poke_mode && (n == 5), 0, vn, ret,
                  use_sd && (m_count + t == stop_at));
            row_left -= t;
            if (row_left == 0) row_left = m_side;
            n++;
        end
        if (n >= budget) begin
            n_checks++; n_err++;
            $display("FAIL feed_budget: stuck at count %0d target %0d", m_count, stop_at);
        end
    endtask

    task automatic settle();
        int n;
        n = 0;
        while (occ > 0 && n < 20) begin
            cycle(0, 0, 0, 0, 0, min2(occ, 16), 0);
            n++;
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_group(input int g);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].grp == g) begin
                cycle(0, 0, 0, 0, tbl[i].vn, tbl[i].ret, tbl[i].sd);
                check($sformatf("tbl_g%0d_%0d_take", g, i), obs_take, tbl[i].exp_take);
            end
        end
    endtask

    task automatic random_drain();
        int kind, err_at, n, vn, ret, t;
        bit sd;
        kind = $urandom_range(0, 3);
        cycle(0, $urandom_range(0, 3), $urandom_range(0, 1), 1,
              $urandom_range(0, 16), $urandom_range(0, min2(occ, 16)), 0);
        err_at = $urandom_range(1, m_vol - 1);
        n = 0;
        while (m_drain && n < 4000) begin
            vn  = $urandom_range(0, 16);
            ret = $urandom_range(0, min2(occ, 16));
            t   = model_take(vn);
            if (kind == 0) sd = (m_count + t >= err_at);
            else           sd = (m_count + t == m_vol) && ($urandom_range(0, 2) == 0);
            cycle(0, $urandom_range(0, 3), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 7) == 0, vn, ret, sd);
            n++;
        end
        if (n >= 4000) begin
            n_checks++; n_err++;
            $display("FAIL random_budget: drain never completed, count %0d", m_count);
        end
        repeat (2) cycle(0, $urandom_range(0, 3), $urandom_range(0, 1), 0,
                         $urandom_range(0, 16), $urandom_range(0, min2(occ, 16)), 0);
    endtask

    initial begin
        // take sequence at 32 credits with no returns, then 5 returned
        tbl[0]  = '{1, 16, 0, 0, 16};
        tbl[1]  = '{1, 16, 0, 0, 16};
        tbl[2]  = '{1, 16, 0, 0, 0};
        tbl[3]  = '{1, 16, 5, 0, 0};
        tbl[4]  = '{1, 16, 0, 0, 5};
        tbl[5]  = '{1, 16, 0, 0, 0};
        // take 16 netted against a return of 16 keeps credit at 32
        tbl[6]  = '{2, 16, 16, 0, 16};
        tbl[7]  = '{2, 16, 0, 0, 16};
        tbl[8]  = '{2, 16, 0, 0, 16};
        tbl[9]  = '{2, 16, 0, 0, 0};
        // credit restored to 32 by reset
        tbl[10] = '{3, 16, 0, 0, 16};
        tbl[11] = '{3, 16, 0, 0, 16};

        // ---------------- clock/reset ----------------
        rst = 1'b1; mode_in = 2'd0; change_mode = 1'b0; drain_start = 1'b0;
        bus.outmap_data = '0; bus.outmap_data_valid_num = '0;
        bus.credit_return = '0; bus.send_done = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();
        #1;

        // Reset state; a full window offered in IDLE must not be taken.
        cycle(0, 0, 0, 0, 16, 0, 0);
        check("rst_take", obs_take, 0);
        check("rst_count", obs_count, 0);
        check("rst_busy", obs_busy, 0);

        // MODE3 credit sequence, then finish to 676 without send_done.
        cycle(0, 2, 1, 1, 16, 0, 0);
        run_group(1);
        feed(676, 0, 0, 300);
        cycle(0, 0, 0, 0, 16, min2(occ, 16), 0);
        check("hold_take", obs_take, 0);
        check("hold_busy", obs_busy, 1);
        check("hold_count", obs_count, 676);
        cycle(0, 0, 0, 0, 16, min2(occ, 16), 1);
        cycle(0, 0, 0, 0, 16, min2(occ, 16), 0);
        check("m3_done", obs_done, 1);
        check("m3_err", obs_err, 0);
        cycle(0, 0, 0, 0, 16, min2(occ, 16), 0);
        check("m3_done_pulse", obs_done, 0);

        // Early send_done at 600 in MODE3.
        settle();
        cycle(0, 0, 0, 1, 0, 0, 0);
        feed(600, 1, 0, 300);
        cycle(0, 0, 0, 0, 16, min2(occ, 16), 0);
        check("early_err", obs_err, 1);
        check("early_done", obs_done, 0);
        check("early_busy", obs_busy, 0);
        cycle(0, 0, 0, 0, 16, min2(occ, 16), 0);
        check("early_idle_take", obs_take, 0);
        check("early_err_sticky", obs_err, 1);

        // Same-cycle take/return netting.
        settle();
        cycle(0, 0, 0, 1, 0, 0, 0);
        run_group(2);
        cycle(1, 0, 0, 0, 0, 0, 0);

        // MODE1 full drain; mode change attempted mid-drain.
        cycle(0, 0, 1, 1, 0, 0, 0);
        feed(12100, 1, 1, 2000);
        cycle(0, 0, 0, 0, 0, min2(occ, 16), 0);
        check("m1_done", obs_done, 1);
        check("m1_err", obs_err, 0);
        check("m1_count", obs_count, 12100);
        settle();
        cycle(0, 0, 0, 1, 0, 0, 0);
        feed(700, 0, 0, 200);
        cycle(0, 0, 0, 0, 0, min2(occ, 16), 0);
        check("keep_mode_count", obs_count, 700);
        check("keep_mode_busy", obs_busy, 1);
        cycle(1, 0, 0, 0, 0, 0, 0);

        // Reset in the middle of a drain at byte_count 300.
        cycle(0, 0, 0, 1, 0, 0, 0);
        feed(300, 0, 0, 100);
        cycle(1, 0, 0, 0, 16, 0, 0);
        cycle(0, 0, 0, 0, 16, 0, 0);
        check("midrst_busy", obs_busy, 0);
        check("midrst_count", obs_count, 0);
        check("midrst_take", obs_take, 0);
        cycle(0, 2, 1, 1, 0, 0, 0);
        run_group(3);
        for (int i = 0; i < 10; i++) begin
            cycle(0, 0, 0, 0, 16, 0, 0);
            check("zero_credit_take", obs_take, 0);
        end
        cycle(0, 0, 0, 0, 0, 0, 0);
`ifdef OFMAP_DRAIN_STALL_CNT_EN
        check("stall_ten", obs_stall, 10);
`endif
        cycle(1, 0, 0, 0, 0, 0, 0);

        // Randomized drains against the model.
        for (int d = 0; d < 10; d++) random_drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ofmap_drain_scheduler.md
Name: ofmap_drain_scheduler

Overview:
Sequences the drain of the output-feature-map buffer into the compressor once a convolution completes. Each cycle it decides how many bytes to take from the buffer's 16-byte read window, based on downstream credit. It forwards those bytes, counts total bytes against the expected ofmap volume, and reports completion or a volume mismatch to the controller.

Parameters:
- MAX_TAKE, 16, maximum bytes taken per cycle (equals the buffer window width).
- CREDIT_DEPTH, 32, downstream byte-FIFO capacity; initial credit.
- L1_SIZE, 55, ofmap side length for modes 0/1.
- L2_SIZE, 13, ofmap side length for mode 2.
- L3_SIZE, 13, ofmap side length for mode 3.
- NUM_FILTER, 4, filters drained per convolution.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mode_in  in  2  op mode: 0=MODE1, 1=MODE2, 2=MODE3, 3=MODE4.
- change_mode  in  1  latch mode_in.
- drain_start  in  1  one-cycle pulse; conv complete, begin drain.
- outmap_data  in  16x8  buffer read window.
- outmap_data_valid_num  in  5  valid bytes in window (0..16).
- send_done  in  1  buffer reports its last take.
- valid_taken_num  out  5  bytes consumed this cycle (combinational).
- cmp_data  out  16x8  bytes to compressor (equals outmap_data).
- cmp_valid_num  out  5  equals valid_taken_num.
- cmp_valid  out  1  valid_taken_num != 0.
- credit_return  in  5  bytes freed downstream this cycle.
- drain_busy  out  1  state == DRAIN.
- drain_done  out  1  one-cycle pulse on successful completion.
- drain_err  out  1  sticky volume-mismatch flag.
- byte_count  out  14  bytes sent in current/last drain.

Behaviour:
- States: IDLE, DRAIN, DONE. Reset → IDLE. credit=CREDIT_DEPTH; mode=MODE1; byte_count=0; drain_err=0; all pulses 0.
- Mode register updates on change_mode only in IDLE; ignored in DRAIN/DONE. If change_mode and drain_start coincide in IDLE, the new mode applies to that drain.
- Side length: S=L1_SIZE for modes 0/1, L2_SIZE for mode 2, L3_SIZE for mode 3. Expected volume E=NUM_FILTER*S*S, latched at drain_start (12100 for L1, 676 for L2/L3).
- IDLE: valid_taken_num=0. drain_start → DRAIN, clearing byte_count and drain_err.
- DRAIN: valid_taken_num = min(outmap_data_valid_num, credit, MAX_TAKE, E-byte_count). Combinational, same cycle. The buffer's window updates on the next clock.
- byte_count += valid_taken_num each cycle in DRAIN.
- Credit each cycle: credit ← credit − valid_taken_num + credit_return. Take and return in the same cycle are netted. Credit saturates at CREDIT_DEPTH. Credit is maintained in all states.
- Completion: send_done with byte_count+valid_taken_num == E → DONE.
- send_done with sum != E → drain_err=1, go to DONE.
- Sum reaching E without send_done → remain in DRAIN with valid_taken_num forced 0 until send_done arrives.
- DONE lasts exactly 1 cycle. drain_done=1 iff drain_err==0. Then → IDLE.
- drain_start outside IDLE is ignored.
- rst mid-drain: immediate IDLE, all counters/credit to reset values, no drain_done.
- cmp_data is passthrough; no added latency.

Optional Feature:
- Macro OFMAP_DRAIN_STALL_CNT_EN.
- Defined: adds output stall_cycles (16 bits). Cleared at drain_start. Increments each DRAIN cycle where outmap_data_valid_num>0 and credit==0. Saturates at 0xFFFF.
- Undefined: port and counter absent; behaviour otherwise identical.

Decomposition:
- Shared package holds the OP_MODE enum (MODE1..MODE4), a new DRAIN_STATE enum (IDLE, DRAIN, DONE), and size constants L1/L2/L3 matching the ofmap size macros.
- One sub-module: drain_credit_counter. Parameter CREDIT_DEPTH; inputs take/return; outputs credit. Holds the saturation and netting logic.

Test Plan:
- MODE1, credit_return mirrors takes, buffer model supplies 16/…/7 per row → 12100 bytes; drain_done pulse on send_done cycle; drain_err=0.
- MODE3, CREDIT_DEPTH=32, no credit_return → takes 16,16 then 0. Returning 5 bytes → next take 5. Total 676 after returns resume.
- send_done injected at byte_count=600 in MODE3 → drain_err=1; no drain_done; IDLE after 1 cycle.
- Take of 16 and credit_return=16 in the same cycle → credit unchanged at 32.
- change_mode to MODE3 during DRAIN → ignored. Next drain still uses prior E=12100.
- rst asserted mid-DRAIN at byte_count=300 → next cycle IDLE, credit=32, byte_count=0. With OFMAP_DRAIN_STALL_CNT_EN, 10 zero-credit cycles → stall_cycles=10.
